// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared BIP constants, opcode encodings and loader state encoding
package bip_pkg;

  localparam int NB_DATA   = 16;
  localparam int NB_OPCODE = 5;
  localparam int NB_BYTE   = 8;

  localparam logic [NB_OPCODE-1:0] OP_HALT                 = 5'd0;
  localparam logic [NB_OPCODE-1:0] OP_STORE                = 5'd1;
  localparam logic [NB_OPCODE-1:0] OP_LOAD                 = 5'd2;
  localparam logic [NB_OPCODE-1:0] OP_LOAD_IMMEDIATE       = 5'd3;
  localparam logic [NB_OPCODE-1:0] OP_ADD                  = 5'd4;
  localparam logic [NB_OPCODE-1:0] OP_ADD_IMMEDIATE        = 5'd5;
  localparam logic [NB_OPCODE-1:0] OP_SUBSTRACT            = 5'd6;
  localparam logic [NB_OPCODE-1:0] OP_SUBSTRACT_IMMEDIATE  = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_HI = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } loader_state_t;

  // Opcode field sits in the top bits of the instruction word; control uses the same helper.
  function automatic logic [NB_OPCODE-1:0] opcode_of(input logic [NB_DATA-1:0] word);
    return word[NB_DATA-1 -: NB_OPCODE];
  endfunction

endpackage

// File: rtl/bip_program_loader.sv
// rtl/bip_program_loader.sv - byte-stream to instruction-memory loader that gates BIP reset/run
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_load,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]            o_imem_data,
  output logic                          o_imem_we,
  output logic                          o_cpu_reset,
  output logic                          o_cpu_valid,
  output logic [LOG2_N_INSMEM_ADDR:0]   o_prog_len,
  output logic                          o_busy,
  output logic                          o_error
);

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);
  localparam logic [LOG2_N_INSMEM_ADDR:0]   MAX_LEN   = (LOG2_N_INSMEM_ADDR + 1)'(N_INSMEM_ADDR);

  loader_state_t                   r_state;
  logic [LOG2_N_INSMEM_ADDR-1:0]   r_addr;
  logic [NB_DATA-1:0]              r_data;
  logic [NB_BYTE-1:0]              r_hi;
  logic                            r_we;
  logic                            r_cpu_reset;
  logic                            r_cpu_valid;
  logic [LOG2_N_INSMEM_ADDR:0]     r_prog_len;
  logic                            r_busy;
  logic                            r_error;
  logic                            w_is_halt;

  assign w_is_halt = (opcode_of(r_data) == OP_HALT);

  // Loader FSM: byte assembly, sequential write addressing and CPU reset/run gating.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_hi        <= '0;
      r_we        <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_cpu_valid <= 1'b0;
      r_prog_len  <= '0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_load) begin
        // Restart from any state; a write already on the bus this cycle still lands.
        r_state     <= ST_WAIT_HI;
        r_addr      <= '0;
        r_prog_len  <= '0;
        r_error     <= 1'b0;
        r_cpu_reset <= 1'b1;
        r_cpu_valid <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          ST_WAIT_HI: begin
            if (i_rx_valid) begin
              r_hi    <= i_rx_data;
              r_state <= ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (i_rx_valid) begin
              r_data  <= {r_hi, i_rx_data};
              r_we    <= 1'b1;
              r_state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (r_prog_len != MAX_LEN) begin
              r_prog_len <= r_prog_len + 1'b1;
            end
            if (w_is_halt) begin
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
              r_cpu_valid <= 1'b1;
              r_busy      <= 1'b0;
            end else if (r_addr == LAST_ADDR) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= ST_WAIT_HI;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_imem_addr = r_addr;
  assign o_imem_data = r_data;
  assign o_imem_we   = r_we;
  assign o_cpu_reset = r_cpu_reset;
  assign o_cpu_valid = r_cpu_valid;
  assign o_prog_len  = r_prog_len;
  assign o_busy      = r_busy;
  assign o_error     = r_error;

endmodule

// File: tb/tb_bip_program_loader.sv
// tb/tb_bip_program_loader.sv - self-checking bench for bip_program_loader
module tb_bip_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        load = 1'b0;
  logic [10:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_we;
  logic        cpu_reset;
  logic        cpu_valid;
  logic [11:0] prog_len;
  logic        busy;
  logic        error;

  int n_pass  = 0;
  int n_total = 0;
  int we_count = 0;
  int zero_writes = 0;

  bip_program_loader dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_load      (load),
    .o_imem_addr (imem_addr),
    .o_imem_data (imem_data),
    .o_imem_we   (imem_we),
    .o_cpu_reset (cpu_reset),
    .o_cpu_valid (cpu_valid),
    .o_prog_len  (prog_len),
    .o_busy      (busy),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      we_count++;
      if (imem_addr == 11'd0) zero_writes++;
    end
  end

  typedef struct {
    logic       ld;
    logic       v;
    logic [7:0] d;
    logic       we;
    int         addr;
    int         data;
    logic       cr;
    logic       cv;
    logic       bsy;
    logic       err;
    int         len;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic v, input logic [7:0] d,
                     input logic we, input int addr, input int data,
                     input logic cr, input logic cv, input logic bsy,
                     input logic err, input int len);
    vec_t t;
    t.ld = ld; t.v = v; t.d = d; t.we = we; t.addr = addr; t.data = data;
    t.cr = cr; t.cv = cv; t.bsy = bsy; t.err = err; t.len = len;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step(input logic ld, input logic v, input logic [7:0] d);
    load = ld; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    load = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic chk_all(input string p, input logic we, input int addr, input int data,
                         input logic cr, input logic cv, input logic bsy, input logic err,
                         input int len);
    chk({p, ".we"},   int'(imem_we),   int'(we));
    chk({p, ".addr"}, int'(imem_addr), addr);
    chk({p, ".data"}, int'(imem_data), data);
    chk({p, ".crst"}, int'(cpu_reset), int'(cr));
    chk({p, ".cval"}, int'(cpu_valid), int'(cv));
    chk({p, ".busy"}, int'(busy),      int'(bsy));
    chk({p, ".err"},  int'(error),     int'(err));
    chk({p, ".len"},  int'(prog_len),  len);
  endtask

  initial begin
    int bad;
    int wc0;

    // Program 1: 0x1805, HALT; then reload in RUN with three words at strobes 2 apart;
    // then load together with a byte strobe (byte must be dropped).
    //   ld v  d      we addr data     cr cv bsy err len
    add(1, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 1, 8'h18, 0, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 1, 8'h05, 1, 0, 16'h1805, 1, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 16'h1805, 1, 0, 1, 0, 1);
    add(0, 1, 8'h00, 0, 1, 16'h1805, 1, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0, 1, 16'h1805, 1, 0, 1, 0, 1);
    add(0, 1, 8'h00, 1, 1, 16'h0000, 1, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 0, 0, 2);
    add(0, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 0, 0, 2);
    add(1, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 1, 8'h21, 0, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 1, 8'h03, 1, 0, 16'h2103, 1, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 16'h2103, 1, 0, 1, 0, 1);
    add(0, 1, 8'h3A, 0, 1, 16'h2103, 1, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0, 1, 16'h2103, 1, 0, 1, 0, 1);
    add(0, 1, 8'h44, 1, 1, 16'h3A44, 1, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0, 2, 16'h3A44, 1, 0, 1, 0, 2);
    add(0, 1, 8'h00, 0, 2, 16'h3A44, 1, 0, 1, 0, 2);
    add(0, 0, 8'h00, 0, 2, 16'h3A44, 1, 0, 1, 0, 2);
    add(0, 1, 8'h07, 1, 2, 16'h0007, 1, 0, 1, 0, 2);
    add(0, 0, 8'h00, 0, 2, 16'h0007, 0, 1, 0, 0, 3);
    add(1, 1, 8'h55, 0, 0, 16'h0007, 1, 0, 1, 0, 0);
    add(0, 1, 8'h00, 0, 0, 16'h0007, 1, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 16'h0007, 1, 0, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 16'h0000, 1, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 16'h0000, 0, 1, 0, 0, 1);

    // Reset values, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_hold", 0, 0, 0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 1, 8'hFF);
    step(0, 1, 8'hFF);
    chk_all("rst_idle", 0, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].v, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
              vecs[i].cr, vecs[i].cv, vecs[i].bsy, vecs[i].err, vecs[i].len);
    end

    // Load restart after a lone high byte: 0xAB is discarded.
    step(1, 0, 8'h00);
    step(0, 1, 8'hAB);
    step(0, 0, 8'h00);
    wc0 = we_count;
    step(1, 0, 8'h00);
    chk_all("restart_load", 0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(0, 1, 8'h00);
    chk_all("restart_wr", 1, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 8'h00);
    chk_all("restart_run", 0, 0, 0, 0, 1, 0, 0, 1);
    chk("restart_wecount", we_count - wc0, 1);

    // Fill all 2048 words without HALT.
    step(1, 0, 8'h00);
    wc0 = we_count;
    zero_writes = 0;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      step(0, 1, 8'h08);
      step(0, 0, 8'h00);
      step(0, 1, 8'h01);
      if (!imem_we || int'(imem_addr) != i || imem_data != 16'h0801) bad++;
      step(0, 0, 8'h00);
    end
    chk("fill_bad_writes", bad, 0);
    chk("fill_wecount", we_count - wc0, 2048);
    chk_all("fill_error", 0, 2047, 16'h0801, 1, 0, 0, 1, 2048);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    chk("fill_no_wrap", we_count - wc0, 2048);
    chk("fill_zero_writes", zero_writes, 1);
    chk_all("fill_error_hold", 0, 2047, 16'h0801, 1, 0, 0, 1, 2048);

    // Asynchronous reset between the high and low bytes.
    step(1, 0, 8'h00);
    step(0, 1, 8'h12);
    chk("areset_pre_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("areset_now", 0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wc0 = we_count;
    step(0, 1, 8'h34);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("areset_no_write", we_count - wc0, 0);
    chk_all("areset_idle", 0, 0, 0, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
